line_buffer_win: RTL and testbench
==================================

# line_buffer_win

Parametrised single-line pixel buffer with a sliding-window read port. Stores up to one image line of `DATA_W`-bit pixels in a circular store and presents `WIN` horizontally adjacent pixels per read. It handles end-of-line tail discard, occupancy and flow-control flags. It feeds the per-row inputs of the convolution window stage and replaces the fixed 8-bit/3-tap line buffer.

## Interface
- `DATA_W`, 8, pixel width in bits
- `LINE_W`, 256, pixels per line and storage depth; any value ≥ `WIN`, not restricted to a power of two
- `WIN`, 3, window width in pixels; 1 ≤ `WIN` ≤ `LINE_W`
- `i_clk`  in  1  clock; all logic is on the rising edge
- `i_rst`  in  1  reset, synchronous, active-high
- `i_data`  in  `DATA_W`  pixel to write
- `i_data_valid`  in  1  write request
- `o_ready`  out  1  space available (count < `LINE_W`)
- `i_rd_data`  in  1  read/advance request
- `o_data`  out  `WIN*DATA_W`  current window
- `o_data_valid`  out  1  window available (count ≥ `WIN`)
- `o_line_done`  out  1  one-cycle pulse after the last window of a line is consumed
- `o_count`  out  `$clog2(LINE_W+1)`  stored pixel count

## Operation
- **Storage:** `LINE_W` × `DATA_W` array. Write pointer `wr` and read pointer `rd` each wrap from `LINE_W-1` to 0 using explicit compare, not bit truncation.
- **Write accepted** = `i_data_valid & o_ready`: `mem[wr] <= i_data`, `wr` advances.
  - A write while full is dropped; no state changes.
- **Window layout:** `o_data` MSB slice = `mem[rd]` (oldest pixel); slice k from the top = `mem[(rd+k) mod LINE_W]`; LSB slice = `mem[(rd+WIN-1) mod LINE_W]`.
- **Column counter** `col`: range 0..`LINE_W-WIN`.
- **Read accepted** = `i_rd_data & o_data_valid`. A read while not valid is ignored.
  - If `col < LINE_W-WIN`: `rd += 1`, count −1, `col += 1`.
  - If `col == LINE_W-WIN` (last window of the line): `rd += WIN` mod `LINE_W`, count −`WIN`, `col <= 0`, `o_line_done` high for the next cycle. This discards the `WIN-1` tail pixels.
- **Count update:** `count <= count + wr_acc − dec`; a simultaneous write and read are both applied.
- **`o_ready` and `o_data_valid`:** both decode the registered count. A read in the same cycle does not free space for a write in that cycle (no bypass).
- **Reset values:** `wr`, `rd`, `col`, `count` = 0; `o_line_done` = 0; `o_ready` = 1; `o_data_valid` = 0.
  - Memory contents are not reset, so `o_data` is don't-care while `o_data_valid` = 0.
  - Reset overrides any simultaneous write or read.

## Timing
- `o_data` is a combinational read of the array at `rd`.
- A write at edge N is visible in `o_count` and `o_data` after edge N. `o_data_valid` rises after the edge that brings count to `WIN`.
- A read at edge N presents the next window after edge N.
- `o_line_done` is registered: high exactly one cycle after the final-window read edge.
- No internal state machine beyond `col`. Throughput is one write and one read per cycle.

## Configuration
- `LINE_BUFFER_WIN_ERR_EN` defined: adds output `o_err` (1 bit, sticky).
  - Set at the edge following a dropped write (`i_data_valid & ~o_ready`) or an ignored read (`i_rd_data & ~o_data_valid`).
  - Cleared only by `i_rst`; reset value 0.
- Macro undefined: no `o_err` port and no error logic. All other behaviour is identical.

## Structure
- **Shared package `line_buffer_pkg`:** default `DATA_W`, `LINE_W`, `WIN`; a pointer-wrap helper function; a count-width function.
- **Sub-module `line_buffer_mem`:** the array with a synchronous write port and `WIN` combinational read taps with modulo addressing.
- Pointer, count, column and flag logic stay in the top module.

## Test plan
Parameters: `DATA_W`=8, `LINE_W`=8, `WIN`=3.
- **Fill to first window:** reset, then write 0x10, 0x11, 0x12 → `o_data_valid` rises after the third write edge; `o_data` = 0x101112; `o_count` = 3.
- **Full line:** write 0x00..0x07, then read 6 times → windows 0x000102 through 0x050607. `o_count` goes 8→3 over the first 5 reads, then 0 after the 6th. `o_line_done` is high exactly the cycle after the 6th read.
- **Full:** write 0x00..0x07 with no reads → `o_ready` = 0. A 9th write (0xFF) is dropped and `o_count` stays 8. With `LINE_BUFFER_WIN_ERR_EN` defined, `o_err` = 1.
- **Wrap and continuation:** write 0x00..0x07, read 3 times (count 5), then write 0x08..0x0A (into slots 0..2, count 8).
  - Reads continue 0x030405, 0x040506, 0x050607, then `o_line_done` pulses.
  - Next window is 0x08090A.
- **Simultaneous access:** at count 5, assert write and read together → count stays 5 and the window advances by 1.
- **Reset mid-line:** at count 6, `col` 2, assert `i_rst` together with a write and a read → next cycle count = 0, `o_data_valid` = 0, `o_ready` = 1, `o_line_done` = 0, `o_err` = 0.

Source files
------------

// File: rtl/line_buffer_pkg.sv
// Shared defaults and helpers for the sliding-window line buffer.
package line_buffer_pkg;

   localparam int unsigned DefDataW = 8;
   localparam int unsigned DefLineW = 256;
   localparam int unsigned DefWin   = 3;

   // Width needed to hold a pixel count in the range 0..line_w.
   function automatic int unsigned cnt_width(input int unsigned line_w);
      return $clog2(line_w + 1);
   endfunction

   // Pointer width, kept at least one bit so a single-entry line still has an address.
   function automatic int unsigned ptr_width(input int unsigned line_w);
      return (line_w > 1) ? $clog2(line_w) : 1;
   endfunction

   // Advance a pointer by inc (inc <= line_w) with an explicit compare.
   // The depth need not be a power of two, so bit truncation cannot be used.
   function automatic int unsigned ptr_wrap_add(input int unsigned ptr,
                                                input int unsigned inc,
                                                input int unsigned line_w);
      int unsigned sum;
      sum = ptr + inc;
      if (sum >= line_w) begin
         sum = sum - line_w;
      end
      return sum;
   endfunction

endpackage

// File: rtl/line_buffer_mem.sv
// Pixel store: one synchronous write port and WIN combinational read taps.
// Tap 0 (oldest pixel) sits in the MSB slice of o_win.
module line_buffer_mem
   import line_buffer_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned LINE_W = DefLineW,
   parameter int unsigned WIN    = DefWin,
   parameter int unsigned PTR_W  = ptr_width(LINE_W)
) (
   input  logic                  i_clk,
   input  logic                  i_we,
   input  logic [PTR_W-1:0]      i_waddr,
   input  logic [DATA_W-1:0]     i_wdata,
   input  logic [PTR_W-1:0]      i_raddr,
   output logic [WIN*DATA_W-1:0] o_win
);

   logic [DATA_W-1:0] mem_q [LINE_W];
   logic [PTR_W-1:0]  tap;

   // Write port; contents are intentionally not reset.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem_q[i_waddr] <= i_wdata;
      end
   end

   // Gather WIN adjacent pixels starting at the read pointer, wrapping modulo LINE_W.
   always_comb begin
      o_win = '0;
      tap   = '0;
      for (int unsigned k = 0; k < WIN; k++) begin
         tap = PTR_W'(ptr_wrap_add(32'(i_raddr), k, LINE_W));
         o_win[(WIN-1-k)*DATA_W +: DATA_W] = mem_q[tap];
      end
   end

endmodule

// File: rtl/line_buffer_win.sv
// Single-line pixel buffer with a WIN-wide sliding read window and tail discard.
// Optional build macro LINE_BUFFER_WIN_ERR_EN adds a sticky o_err flag for
// dropped writes and ignored reads.
module line_buffer_win
   import line_buffer_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned LINE_W = DefLineW,
   parameter int unsigned WIN    = DefWin
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [DATA_W-1:0]             i_data,
   input  logic                          i_data_valid,
   output logic                          o_ready,
   input  logic                          i_rd_data,
   output logic [WIN*DATA_W-1:0]         o_data,
   output logic                          o_data_valid,
   output logic                          o_line_done,
`ifdef LINE_BUFFER_WIN_ERR_EN
   output logic                          o_err,
`endif
   output logic [cnt_width(LINE_W)-1:0]  o_count
);

   localparam int unsigned PTR_W = ptr_width(LINE_W);
   localparam int unsigned CNT_W = cnt_width(LINE_W);

   localparam logic [CNT_W-1:0] LineWC   = CNT_W'(LINE_W);
   localparam logic [CNT_W-1:0] WinC     = CNT_W'(WIN);
   localparam logic [CNT_W-1:0] ColLastC = CNT_W'(LINE_W - WIN);

   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [CNT_W-1:0] col_q, col_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] dec;
   logic             wr_acc;
   logic             rd_acc;

   // Flags decode the registered count only; a same-cycle read never frees space.
   always_comb begin
      o_ready      = (count_q < LineWC);
      o_data_valid = (count_q >= WinC);
      wr_acc       = i_data_valid & o_ready;
      rd_acc       = i_rd_data & o_data_valid;
   end

   // Next-state for pointers, column, count and the end-of-line pulse.
   always_comb begin
      wr_d   = wr_q;
      rd_d   = rd_q;
      col_d  = col_q;
      dec    = '0;
      done_d = 1'b0;
      if (wr_acc) begin
         wr_d = PTR_W'(ptr_wrap_add(32'(wr_q), 1, LINE_W));
      end
      if (rd_acc) begin
         if (col_q == ColLastC) begin
            // Last window: skip the WIN-1 tail pixels so the next line starts aligned.
            rd_d   = PTR_W'(ptr_wrap_add(32'(rd_q), WIN, LINE_W));
            col_d  = '0;
            dec    = WinC;
            done_d = 1'b1;
         end else begin
            rd_d  = PTR_W'(ptr_wrap_add(32'(rd_q), 1, LINE_W));
            col_d = col_q + 1'b1;
            dec   = CNT_W'(1);
         end
      end
      count_d = count_q + CNT_W'(wr_acc) - dec;
   end

   // State registers with synchronous reset taking priority over any access.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         col_q   <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         col_q   <= col_d;
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

`ifdef LINE_BUFFER_WIN_ERR_EN
   logic err_q, err_d;

   // Sticky error: any dropped write or ignored read sets it until reset.
   always_comb begin
      err_d = err_q | (i_data_valid & ~o_ready) | (i_rd_data & ~o_data_valid);
   end

   // Error flag register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign o_err = err_q;
`endif

   assign o_line_done = done_q;
   assign o_count     = count_q;

   line_buffer_mem #(
      .DATA_W (DATA_W),
      .LINE_W (LINE_W),
      .WIN    (WIN),
      .PTR_W  (PTR_W)
   ) u_mem (
      .i_clk   (i_clk),
      .i_we    (wr_acc),
      .i_waddr (wr_q),
      .i_wdata (i_data),
      .i_raddr (rd_q),
      .o_win   (o_data)
   );

endmodule

// File: tb/tb_line_buffer_win.sv
// Table-driven bench for line_buffer_win (DATA_W=8, LINE_W=8, WIN=3) with a
// pixel-queue scoreboard for window contents.
module tb_line_buffer_win;

   localparam int unsigned DW = 8;
   localparam int unsigned LW = 8;
   localparam int unsigned WN = 3;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic [DW-1:0] i_data;
   logic          i_data_valid;
   logic          o_ready;
   logic          i_rd_data;
   logic [WN*DW-1:0] o_data;
   logic          o_data_valid;
   logic          o_line_done;
   logic [3:0]    o_count;
`ifdef LINE_BUFFER_WIN_ERR_EN
   logic          o_err;
`endif

   always #5 i_clk = ~i_clk;

   line_buffer_win #(
      .DATA_W (DW),
      .LINE_W (LW),
      .WIN    (WN)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_data       (i_data),
      .i_data_valid (i_data_valid),
      .o_ready      (o_ready),
      .i_rd_data    (i_rd_data),
      .o_data       (o_data),
      .o_data_valid (o_data_valid),
      .o_line_done  (o_line_done),
`ifdef LINE_BUFFER_WIN_ERR_EN
      .o_err        (o_err),
`endif
      .o_count      (o_count)
   );

   typedef struct {
      logic       rst;
      logic       wv;
      logic [7:0] wd;
      logic       rd;
      int         cnt;   // expected o_count after the edge
      logic       dn;    // expected o_line_done after the edge
   } vec_t;

   vec_t        vecs[$];
   logic [7:0]  pix_q[$];        // pixels currently held, oldest first
   logic [23:0] exp_win_q[$];    // expected windows awaiting comparison
   int          mcol;
   logic        merr;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic add(input logic rst, input logic wv, input logic [7:0] wd, input logic rd,
                      input int cnt, input logic dn);
      vec_t v;
      v.rst = rst; v.wv = wv; v.wd = wd; v.rd = rd; v.cnt = cnt; v.dn = dn;
      vecs.push_back(v);
   endtask

   // Reference behaviour: pixel queue with a column counter and tail discard.
   task automatic model_step(input vec_t v);
      int   size;
      logic wacc, racc;
      size = pix_q.size();
      if (v.rst) begin
         pix_q.delete();
         mcol = 0;
         merr = 1'b0;
      end else begin
         wacc = v.wv && (size < int'(LW));
         racc = v.rd && (size >= int'(WN));
         if ((v.wv && !(size < int'(LW))) || (v.rd && !(size >= int'(WN)))) merr = 1'b1;
         if (racc) begin
            if (mcol == int'(LW - WN)) begin
               for (int j = 0; j < int'(WN); j++) void'(pix_q.pop_front());
               mcol = 0;
            end else begin
               void'(pix_q.pop_front());
               mcol++;
            end
         end
         if (wacc) pix_q.push_back(v.wd);
      end
      if (pix_q.size() >= int'(WN)) exp_win_q.push_back({pix_q[0], pix_q[1], pix_q[2]});
   endtask

   initial begin
      i_rst = 1'b0; i_data = '0; i_data_valid = 1'b0; i_rd_data = 1'b0;
      mcol = 0; merr = 1'b0;

      // Fill, overflow, drain a whole line, ignored read.
      add(1, 0, 8'h00, 0, 0, 0);
      for (int j = 0; j < 8; j++) add(0, 1, 8'(8'h10 + j), 0, j + 1, 0);
      add(0, 1, 8'hFF, 0, 8, 0);
      for (int j = 0; j < 5; j++) add(0, 0, 8'h00, 1, 7 - j, 0);
      add(0, 0, 8'h00, 1, 0, 1);
      add(0, 0, 8'h00, 0, 0, 0);
      add(0, 0, 8'h00, 1, 0, 0);
      add(1, 0, 8'h00, 0, 0, 0);
      // Wrap and continuation with a simultaneous write+read.
      for (int j = 0; j < 8; j++) add(0, 1, 8'(j), 0, j + 1, 0);
      add(0, 0, 8'h00, 1, 7, 0);
      add(0, 0, 8'h00, 1, 6, 0);
      add(0, 0, 8'h00, 1, 5, 0);
      add(0, 1, 8'h08, 1, 5, 0);
      add(0, 1, 8'h09, 0, 6, 0);
      add(0, 1, 8'h0A, 0, 7, 0);
      add(0, 0, 8'h00, 1, 6, 0);
      add(0, 0, 8'h00, 1, 3, 1);
      add(0, 0, 8'h00, 0, 3, 0);
      // Reset mid-line (count 6, col 2) alongside a write and a read.
      add(0, 1, 8'h0B, 0, 4, 0);
      add(0, 1, 8'h0C, 0, 5, 0);
      add(0, 1, 8'h0D, 0, 6, 0);
      add(0, 0, 8'h00, 1, 5, 0);
      add(0, 1, 8'h0E, 1, 5, 0);
      add(0, 1, 8'h0F, 0, 6, 0);
      add(1, 1, 8'h55, 1, 0, 0);
      // Full with read: the read is taken, the write is dropped.
      for (int j = 0; j < 8; j++) add(0, 1, 8'(8'h20 + j), 0, j + 1, 0);
      add(0, 1, 8'h99, 1, 7, 0);

      foreach (vecs[i]) begin
         i_rst        = vecs[i].rst;
         i_data_valid = vecs[i].wv;
         i_data       = vecs[i].wd;
         i_rd_data    = vecs[i].rd;
         model_step(vecs[i]);
         @(posedge i_clk);
         #1;
         check($sformatf("count[%0d]", i), 32'(o_count), 32'(vecs[i].cnt));
         check($sformatf("valid[%0d]", i), 32'(o_data_valid), 32'(vecs[i].cnt >= int'(WN)));
         check($sformatf("ready[%0d]", i), 32'(o_ready), 32'(vecs[i].cnt < int'(LW)));
         check($sformatf("line_done[%0d]", i), 32'(o_line_done), 32'(vecs[i].dn));
`ifdef LINE_BUFFER_WIN_ERR_EN
         check($sformatf("err[%0d]", i), 32'(o_err), 32'(merr));
`endif
         if (exp_win_q.size() > 0) begin
            check($sformatf("window[%0d]", i), 32'(o_data), 32'(exp_win_q.pop_front()));
         end
      end

      // Hand-written fill-to-first-window sequence.
      i_rst = 1'b1; i_data_valid = 1'b0; i_rd_data = 1'b0;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      check("rst_ready", 32'(o_ready), 32'd1);
      check("rst_valid", 32'(o_data_valid), 32'd0);
      i_data_valid = 1'b1; i_data = 8'h10;
      @(posedge i_clk); #1;
      i_data = 8'h11;
      @(posedge i_clk); #1;
      check("fill2_valid", 32'(o_data_valid), 32'd0);
      check("fill2_count", 32'(o_count), 32'd2);
      i_data = 8'h12;
      @(posedge i_clk); #1;
      i_data_valid = 1'b0;
      check("fill3_valid", 32'(o_data_valid), 32'd1);
      check("fill3_count", 32'(o_count), 32'd3);
      check("fill3_window", 32'(o_data), 32'h101112);
      @(posedge i_clk); #1;
      check("hold_window", 32'(o_data), 32'h101112);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
